// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared valid/ready memory port: locked instruction
// refill bursts, single-beat data grants, round-robin between them. Optional perf counters under MEMARB_PERF_EN.
module mem_port_arbiter #(
  parameter int unsigned BURST_BEATS = 4,
  parameter int unsigned LOCK_IDLE   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic [31:0] i_req_rdata,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  input  logic [3:0]  d_req_wstrb,
  output logic [31:0] d_req_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic [31:0] mem_req_rdata
`ifdef MEMARB_PERF_EN
  ,
  output logic [31:0] perf_i_bursts,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_d_wait
`endif
);

  localparam int unsigned BW = $clog2(BURST_BEATS + 1);
  localparam int unsigned IW = $clog2(LOCK_IDLE + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  state_t        state;
  logic          last;
  logic [BW-1:0] beat_cnt;
  logic [IW-1:0] idle_cnt;

  logic take_i_c;
  logic take_d_c;
  logic i_beat_c;
  logic d_beat_c;
  logic i_last_beat_c;
  logic i_timeout_c;

  // Round-robin pick in IDLE: on a tie the side that was not granted last wins.
  assign take_i_c = (state == IDLE) && i_req_valid && (!d_req_valid || last);
  assign take_d_c = (state == IDLE) && d_req_valid && !take_i_c;

  assign i_beat_c = (state == GRANT_I) && mem_req_ready && i_req_valid;
  assign d_beat_c = (state == GRANT_D) && mem_req_ready && d_req_valid;

  assign i_last_beat_c = i_beat_c && (beat_cnt == BW'(BURST_BEATS - 1));
  assign i_timeout_c   = !i_req_valid && (idle_cnt == IW'(LOCK_IDLE - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      beat_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (take_i_c) begin
            state    <= GRANT_I;
            last     <= 1'b0;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end else if (take_d_c) begin
            state    <= GRANT_D;
            last     <= 1'b1;
            beat_cnt <= '0;
            idle_cnt <= '0;
          end
        end
        GRANT_I: begin
          if (i_beat_c) begin
            beat_cnt <= beat_cnt + BW'(1);
          end
          if (i_req_valid) begin
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
          // Burst ends on its final beat or after a long enough valid gap.
          if (i_last_beat_c || i_timeout_c) begin
            state <= IDLE;
          end
        end
        GRANT_D: begin
          if (d_beat_c) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side mux selected by the registered grant.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_addr  = 32'd0;
    mem_req_wdata = 32'd0;
    mem_req_wstrb = 4'd0;
    case (state)
      GRANT_I: begin
        mem_req_valid = i_req_valid;
        mem_req_addr  = i_req_addr;
      end
      GRANT_D: begin
        mem_req_valid = d_req_valid;
        mem_req_addr  = d_req_addr;
        mem_req_wdata = d_req_wdata;
        mem_req_wstrb = d_req_wstrb;
      end
      default: ;
    endcase
  end

  assign i_req_ready = i_beat_c;
  assign d_req_ready = d_beat_c;
  assign i_req_rdata = mem_req_rdata;
  assign d_req_rdata = mem_req_rdata;

`ifdef MEMARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_i_bursts <= '0;
      perf_d_grants <= '0;
      perf_d_wait   <= '0;
    end else begin
      if (take_i_c) begin
        perf_i_bursts <= perf_i_bursts + 32'd1;
      end
      if (take_d_c) begin
        perf_d_grants <= perf_d_grants + 32'd1;
      end
      if (d_req_valid && (state != GRANT_D)) begin
        perf_d_wait <= perf_d_wait + 32'd1;
      end
    end
  end
`endif

endmodule
